// File: rtl/opicorv32_pcpi_arbiter.sv
// PCPI arbiter: broadcasts each core request to N_CP coprocessors, hands ownership
// to the lowest-index claimer and returns its result as a registered ready pulse.
module opicorv32_pcpi_arbiter #(
  parameter int  N_CP    = 2,
  parameter int  TIMEOUT = 12,
  localparam int OW      = (N_CP > 2) ? $clog2(N_CP) : 1,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_pcpi_valid,
  input  logic [31:0]         i_pcpi_insn,
  input  logic [31:0]         i_pcpi_rs1,
  input  logic [31:0]         i_pcpi_rs2,
  output logic                o_pcpi_wr,
  output logic [31:0]         o_pcpi_rd,
  output logic                o_pcpi_wait,
  output logic                o_pcpi_ready,
  output logic [N_CP-1:0]     o_cp_valid,
  output logic [31:0]         o_cp_insn,
  output logic [31:0]         o_cp_rs1,
  output logic [31:0]         o_cp_rs2,
  input  logic [N_CP-1:0]     i_cp_wr,
  input  logic [32*N_CP-1:0]  i_cp_rd,
  input  logic [N_CP-1:0]     i_cp_wait,
  input  logic [N_CP-1:0]     i_cp_ready,
  output logic [OW-1:0]       o_cp_owner,
  output logic                o_timeout
);

  // IDLE no request | PROBE broadcast, find claimer | OWNED owner computing | RESP ready pulse | DRAIN wait for valid low
  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_OWNED,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tmr;
  logic [TW-1:0]   w_tmr_nxt;

  logic [N_CP-1:0] w_claim;
  logic            w_found;
  logic [OW-1:0]   w_owner;
  logic            w_new_ready;
  logic            w_new_wr;
  logic [31:0]     w_new_rd;
  logic [N_CP-1:0] w_new_oh;
  logic [N_CP-1:0] w_cur_oh;
  logic            w_cur_ready;
  logic            w_cur_wr;
  logic [31:0]     w_cur_rd;

  logic [N_CP-1:0] w_cp_valid_nxt;
  logic            w_wait_nxt;
  logic            w_ready_nxt;
  logic            w_wr_nxt;
  logic [31:0]     w_rd_nxt;
  logic [OW-1:0]   w_owner_nxt;
  logic            w_timeout_nxt;

  assign o_cp_insn = i_pcpi_insn;
  assign o_cp_rs1  = i_pcpi_rs1;
  assign o_cp_rs2  = i_pcpi_rs2;
  assign w_claim   = i_cp_wait | i_cp_ready;

  // Scan downwards so the lowest claiming index is the last one written.
  always_comb begin
    w_found     = 1'b0;
    w_owner     = '0;
    w_new_ready = 1'b0;
    w_new_wr    = 1'b0;
    w_new_rd    = '0;
    for (int i = N_CP - 1; i >= 0; i--) begin
      if (w_claim[i]) begin
        w_found     = 1'b1;
        w_owner     = OW'(i);
        w_new_ready = i_cp_ready[i];
        w_new_wr    = i_cp_wr[i];
        w_new_rd    = i_cp_rd[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_new_oh    = '0;
    w_cur_oh    = '0;
    w_cur_ready = 1'b0;
    w_cur_wr    = 1'b0;
    w_cur_rd    = '0;
    for (int i = 0; i < N_CP; i++) begin
      if (w_owner == OW'(i)) begin
        w_new_oh[i] = 1'b1;
      end
      if (o_cp_owner == OW'(i)) begin
        w_cur_oh[i] = 1'b1;
        w_cur_ready = i_cp_ready[i];
        w_cur_wr    = i_cp_wr[i];
        w_cur_rd    = i_cp_rd[32*i +: 32];
      end
    end
  end

  // Outputs are computed for the next state and registered with it.
  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = r_tmr;
    w_cp_valid_nxt = '0;
    w_wait_nxt     = 1'b0;
    w_ready_nxt    = 1'b0;
    w_wr_nxt       = 1'b0;
    w_rd_nxt       = '0;
    w_owner_nxt    = o_cp_owner;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_pcpi_valid) begin
          w_state_nxt    = S_PROBE;
          w_tmr_nxt      = '0;
          w_cp_valid_nxt = '1;
        end
      end
      S_PROBE: begin
        if (!i_pcpi_valid) begin
          w_state_nxt = S_IDLE;
        end else if (w_found) begin
          w_owner_nxt = w_owner;
          if (w_new_ready) begin
            w_state_nxt = S_RESP;
            w_ready_nxt = 1'b1;
            w_wr_nxt    = w_new_wr;
            w_rd_nxt    = w_new_rd;
          end else begin
            w_state_nxt    = S_OWNED;
            w_cp_valid_nxt = w_new_oh;
            w_wait_nxt     = 1'b1;
          end
        end else if (r_tmr == TW'(TIMEOUT - 1)) begin
          w_state_nxt   = S_DRAIN;
          w_timeout_nxt = 1'b1;
        end else begin
          w_tmr_nxt      = r_tmr + TW'(1);
          w_cp_valid_nxt = '1;
        end
      end
      S_OWNED: begin
        if (!i_pcpi_valid) begin
          w_state_nxt = S_IDLE;
        end else if (w_cur_ready) begin
          w_state_nxt = S_RESP;
          w_ready_nxt = 1'b1;
          w_wr_nxt    = w_cur_wr;
          w_rd_nxt    = w_cur_rd;
        end else begin
          w_cp_valid_nxt = w_cur_oh;
          w_wait_nxt     = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!i_pcpi_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      o_cp_valid   <= '0;
      o_pcpi_wait  <= 1'b0;
      o_pcpi_ready <= 1'b0;
      o_pcpi_wr    <= 1'b0;
      o_pcpi_rd    <= '0;
      o_cp_owner   <= '0;
      o_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmr        <= w_tmr_nxt;
      o_cp_valid   <= w_cp_valid_nxt;
      o_pcpi_wait  <= w_wait_nxt;
      o_pcpi_ready <= w_ready_nxt;
      o_pcpi_wr    <= w_wr_nxt;
      o_pcpi_rd    <= w_rd_nxt;
      o_cp_owner   <= w_owner_nxt;
      o_timeout    <= w_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_opicorv32_pcpi_arbiter.sv
// Bench for the PCPI arbiter: bench-driven coprocessor behaviour per scenario,
// expected core results queued at request time and checked when pcpi_ready fires.
module tb_opicorv32_pcpi_arbiter;

  localparam int N_CP    = 2;
  localparam int TIMEOUT = 12;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic [1:0]  cp_valid;
  logic [31:0] cp_insn;
  logic [31:0] cp_rs1;
  logic [31:0] cp_rs2;
  logic [1:0]  cp_wr;
  logic [63:0] cp_rd;
  logic [1:0]  cp_wait;
  logic [1:0]  cp_ready;
  logic [0:0]  cp_owner;
  logic        timeout;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  opicorv32_pcpi_arbiter #(.N_CP(N_CP), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_pcpi_valid (pcpi_valid),
    .i_pcpi_insn  (pcpi_insn),
    .i_pcpi_rs1   (pcpi_rs1),
    .i_pcpi_rs2   (pcpi_rs2),
    .o_pcpi_wr    (pcpi_wr),
    .o_pcpi_rd    (pcpi_rd),
    .o_pcpi_wait  (pcpi_wait),
    .o_pcpi_ready (pcpi_ready),
    .o_cp_valid   (cp_valid),
    .o_cp_insn    (cp_insn),
    .o_cp_rs1     (cp_rs1),
    .o_cp_rs2     (cp_rs2),
    .i_cp_wr      (cp_wr),
    .i_cp_rd      (cp_rd),
    .i_cp_wait    (cp_wait),
    .i_cp_ready   (cp_ready),
    .o_cp_owner   (cp_owner),
    .o_timeout    (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cp();
    cp_wait  = 2'b00;
    cp_ready = 2'b00;
    cp_wr    = 2'b00;
    cp_rd    = '0;
  endtask

  task automatic wait_ready(input int bound, output bit got, output int cycles);
    got    = 1'b0;
    cycles = 0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (pcpi_ready === 1'b1) begin
        got    = 1'b1;
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    clear_cp();
    tick();
    tick();
    n_cmp++;
    if ({cp_valid, pcpi_ready, pcpi_wait, pcpi_wr, cp_owner, timeout} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 0000000", {cp_valid, pcpi_ready, pcpi_wait, pcpi_wr, cp_owner, timeout});
    end
    n_cmp++;
    if (pcpi_rd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rd: got %h required 00000000", pcpi_rd);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_owner();
    bit   got;
    int   cyc;
    exp_t e;
    sb_q.push_back('{wr: 1'b1, rd: 32'h1234_5678});
    pcpi_insn  = 32'h0220_81B3;
    pcpi_rs1   = 32'h0000_0007;
    pcpi_rs2   = 32'h0000_0009;
    pcpi_valid = 1'b1;
    tick();
    n_cmp++;
    if (cp_valid !== 2'b11 || pcpi_wait !== 1'b0) begin
      n_err++;
      $display("FAIL s1_probe: cp_valid=%b wait=%b required 11/0", cp_valid, pcpi_wait);
    end
    n_cmp++;
    if (cp_insn !== 32'h0220_81B3 || cp_rs1 !== 32'h7 || cp_rs2 !== 32'h9) begin
      n_err++;
      $display("FAIL s1_passthru: insn=%h rs1=%h rs2=%h required 022081b3/7/9", cp_insn, cp_rs1, cp_rs2);
    end
    tick();
    tick();
    cp_wait = 2'b01;
    tick();
    n_cmp++;
    if (cp_valid !== 2'b01 || pcpi_wait !== 1'b1 || cp_owner !== 1'b0) begin
      n_err++;
      $display("FAIL s1_owned: cp_valid=%b wait=%b owner=%b required 01/1/0", cp_valid, pcpi_wait, cp_owner);
    end
    tick();
    cp_ready         = 2'b01;
    cp_wr            = 2'b01;
    cp_rd[31:0]      = 32'h1234_5678;
    wait_ready(8, got, cyc);
    n_cmp++;
    if (!got || cyc != 0) begin
      n_err++;
      $display("FAIL s1_latency: got=%0d cycles=%0d required 1/0", got, cyc);
    end
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL s1_sb_empty: queue size 0 required 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if (pcpi_rd !== e.rd || pcpi_wr !== e.wr) begin
        n_err++;
        $display("FAIL s1_result: rd=%h wr=%b required %h/%b", pcpi_rd, pcpi_wr, e.rd, e.wr);
      end
    end
    n_cmp++;
    if (cp_valid !== 2'b00 || pcpi_wait !== 1'b0) begin
      n_err++;
      $display("FAIL s1_resp_ctrl: cp_valid=%b wait=%b required 00/0", cp_valid, pcpi_wait);
    end
    clear_cp();
    tick();
    n_cmp++;
    if (pcpi_ready !== 1'b0 || pcpi_rd !== 32'h0 || pcpi_wr !== 1'b0) begin
      n_err++;
      $display("FAIL s1_pulse_len: ready=%b rd=%h wr=%b required 0/0/0", pcpi_ready, pcpi_rd, pcpi_wr);
    end
    pcpi_valid = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous_claim();
    bit   got;
    int   cyc;
    int   seen;
    exp_t e;
    sb_q.push_back('{wr: 1'b1, rd: 32'hCAFE_0001});
    pcpi_valid = 1'b1;
    tick();
    cp_wait = 2'b11;
    tick();
    n_cmp++;
    if (cp_owner !== 1'b0 || cp_valid !== 2'b01) begin
      n_err++;
      $display("FAIL s2_priority: owner=%b cp_valid=%b required 0/01", cp_owner, cp_valid);
    end
    cp_ready      = 2'b10;
    cp_wr         = 2'b10;
    cp_rd[63:32]  = 32'hDEAD_BEEF;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (pcpi_ready === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0 || pcpi_wait !== 1'b1) begin
      n_err++;
      $display("FAIL s2_nonowner_ignored: ready pulses=%0d wait=%b required 0/1", seen, pcpi_wait);
    end
    cp_ready      = 2'b11;
    cp_wr         = 2'b01;
    cp_rd[31:0]   = 32'hCAFE_0001;
    wait_ready(8, got, cyc);
    n_cmp++;
    if (!got || cyc != 0) begin
      n_err++;
      $display("FAIL s2_latency: got=%0d cycles=%0d required 1/0", got, cyc);
    end
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL s2_sb_empty: queue size 0 required 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if (pcpi_rd !== e.rd || pcpi_wr !== e.wr) begin
        n_err++;
        $display("FAIL s2_result: rd=%h wr=%b required %h/%b", pcpi_rd, pcpi_wr, e.rd, e.wr);
      end
    end
    clear_cp();
    tick();
    pcpi_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bit got;
    int n_probe;
    int seen;
    pcpi_valid = 1'b1;
    got     = 1'b0;
    n_probe = 0;
    seen    = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (pcpi_ready === 1'b1) seen++;
      if (timeout === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (cp_valid === 2'b11) n_probe++;
    end
    n_cmp++;
    if (!got || n_probe != TIMEOUT) begin
      n_err++;
      $display("FAIL s3_timeout_cycles: seen=%0d probe_cycles=%0d required 1/%0d", got, n_probe, TIMEOUT);
    end
    n_cmp++;
    if (cp_valid !== 2'b00 || seen != 0) begin
      n_err++;
      $display("FAIL s3_release: cp_valid=%b ready pulses=%0d required 00/0", cp_valid, seen);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b0 || cp_valid !== 2'b00 || pcpi_ready !== 1'b0) begin
      n_err++;
      $display("FAIL s3_drain: timeout=%b cp_valid=%b ready=%b required 0/00/0", timeout, cp_valid, pcpi_ready);
    end
    tick();
    n_cmp++;
    if (cp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL s3_no_reprobe: cp_valid=%b required 00", cp_valid);
    end
    pcpi_valid = 1'b0;
    tick();
    pcpi_valid = 1'b1;
    tick();
    n_cmp++;
    if (cp_valid !== 2'b11) begin
      n_err++;
      $display("FAIL s3_idle_reprobe: cp_valid=%b required 11", cp_valid);
    end
    pcpi_valid = 1'b0;
    tick();
    n_cmp++;
    if (cp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL s3_probe_abort: cp_valid=%b required 00", cp_valid);
    end
    tick();
  endtask

  task automatic test_abort_owned();
    int seen;
    pcpi_valid = 1'b1;
    tick();
    cp_wait = 2'b10;
    tick();
    n_cmp++;
    if (cp_owner !== 1'b1 || cp_valid !== 2'b10 || pcpi_wait !== 1'b1) begin
      n_err++;
      $display("FAIL s4_owned_cp1: owner=%b cp_valid=%b wait=%b required 1/10/1", cp_owner, cp_valid, pcpi_wait);
    end
    pcpi_valid = 1'b0;
    tick();
    n_cmp++;
    if (cp_valid !== 2'b00 || pcpi_wait !== 1'b0) begin
      n_err++;
      $display("FAIL s4_abort: cp_valid=%b wait=%b required 00/0", cp_valid, pcpi_wait);
    end
    cp_ready     = 2'b10;
    cp_wr        = 2'b10;
    cp_rd[63:32] = 32'h1111_2222;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (pcpi_ready === 1'b1 || cp_valid !== 2'b00) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL s4_late_ready: bad cycles=%0d required 0", seen);
    end
    clear_cp();
    tick();
  endtask

  task automatic test_reset_mid();
    bit   got;
    int   cyc;
    exp_t e;
    pcpi_valid = 1'b1;
    tick();
    cp_wait = 2'b10;
    tick();
    n_cmp++;
    if (pcpi_wait !== 1'b1 || cp_owner !== 1'b1) begin
      n_err++;
      $display("FAIL s5_owned: wait=%b owner=%b required 1/1", pcpi_wait, cp_owner);
    end
    resetn   = 1'b0;
    cp_ready = 2'b10;
    cp_rd[63:32] = 32'h3333_4444;
    tick();
    n_cmp++;
    if ({cp_valid, pcpi_ready, pcpi_wait, pcpi_wr, cp_owner, timeout} !== 7'b0 || pcpi_rd !== 32'h0) begin
      n_err++;
      $display("FAIL s5_reset_outputs: ctrl=%b rd=%h required 0000000/00000000",
               {cp_valid, pcpi_ready, pcpi_wait, pcpi_wr, cp_owner, timeout}, pcpi_rd);
    end
    resetn     = 1'b1;
    pcpi_valid = 1'b0;
    clear_cp();
    tick();
    sb_q.push_back('{wr: 1'b1, rd: 32'hA5A5_0005});
    pcpi_valid = 1'b1;
    tick();
    cp_wait     = 2'b01;
    cp_ready    = 2'b01;
    cp_wr       = 2'b01;
    cp_rd[31:0] = 32'hA5A5_0005;
    wait_ready(8, got, cyc);
    n_cmp++;
    if (!got || cyc != 0) begin
      n_err++;
      $display("FAIL s5_min_latency: got=%0d cycles=%0d required 1/0", got, cyc);
    end
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL s5_sb_empty: queue size 0 required 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if (pcpi_rd !== e.rd || pcpi_wr !== e.wr) begin
        n_err++;
        $display("FAIL s5_result: rd=%h wr=%b required %h/%b", pcpi_rd, pcpi_wr, e.rd, e.wr);
      end
    end
    clear_cp();
    tick();
    pcpi_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit   got;
    int   cyc;
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      sb_q.push_back('{wr: (r == 0), rd: 32'(r + 1)});
      pcpi_valid = 1'b1;
      tick();
      n_cmp++;
      if (cp_valid !== 2'b11 || pcpi_ready !== 1'b0 || pcpi_rd !== 32'h0) begin
        n_err++;
        $display("FAIL s6_probe_%0d: cp_valid=%b ready=%b rd=%h required 11/0/00000000", r, cp_valid, pcpi_ready, pcpi_rd);
      end
      cp_wait      = 2'b10;
      cp_ready     = 2'b10;
      cp_wr        = (r == 0) ? 2'b10 : 2'b00;
      cp_rd[63:32] = 32'(r + 1);
      wait_ready(8, got, cyc);
      n_cmp++;
      if (!got || cyc != 0) begin
        n_err++;
        $display("FAIL s6_latency_%0d: got=%0d cycles=%0d required 1/0", r, got, cyc);
      end
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL s6_sb_empty_%0d: queue size 0 required 1", r);
      end else begin
        e = sb_q.pop_front();
        n_cmp++;
        if (pcpi_rd !== e.rd || pcpi_wr !== e.wr) begin
          n_err++;
          $display("FAIL s6_result_%0d: rd=%h wr=%b required %h/%b", r, pcpi_rd, pcpi_wr, e.rd, e.wr);
        end
      end
      clear_cp();
      tick();
      pcpi_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_simultaneous_claim();
    test_timeout();
    test_abort_owned();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drained: %0d entries left required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
